assoc_cache_ctrl: RTL and testbench

Parametrised fully-associative write-back cache controller with true-LRU replacement, placed between a requester (switch/CPU side) and a fixed-latency single-port RAM. It generalises way count, address/data width and RAM latency. Over the current 4-way design it adds:
- a valid/ready request handshake;
- an explicit response strobe;
- a proper reset;
- invalid-way-first victim selection.

---
 rtl/assoc_cache_pkg.sv | 25 ++
 rtl/assoc_cache_ctrl_lru.sv | 48 ++++
 rtl/assoc_cache_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_assoc_cache_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_cache_pkg.sv
// assoc_cache_pkg
// Shared types for the fully-associative write-back cache controller:
//   state_t      - controller FSM states (IDLE/WB/FILL/RESP)
//   line_flags_t - per-line valid/dirty flags; the owning module wraps these
//                  with its own tag/data widths into its line record
//   age_width()  - width of an LRU age register, clog2(WAYS)
package assoc_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic dirty;
    } line_flags_t;

    function automatic int age_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/assoc_cache_ctrl_lru.sv
// lru_age_table
// True-LRU age registers for WAYS ways. Ages always form a permutation of
// 0..WAYS-1 (0 = most recently used). Reset sets age[i] = i.
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   touch_en/way      make touch_way the youngest; all younger ways age by one
//   valid_vec         per-way valid flags, used for invalid-first selection
//   victim            lowest-index invalid way, else the way with the oldest age
module lru_age_table
    import assoc_cache_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int AW   = age_width(WAYS)
)
(
    input  logic            clock,
    input  logic            reset,
    input  logic            touch_en,
    input  logic [AW-1:0]   touch_way,
    input  logic [WAYS-1:0] valid_vec,
    output logic [AW-1:0]   victim
);

    logic [AW-1:0] age [WAYS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WAYS; i++) age[i] <= AW'(i);
        end else if (touch_en) begin
            for (int i = 0; i < WAYS; i++) begin
                if (AW'(i) == touch_way)
                    age[i] <= '0;
                else if (age[i] < age[touch_way])
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

    // Second loop runs downwards so the lowest-index invalid way wins.
    always_comb begin
        victim = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (age[i] == AW'(WAYS - 1)) victim = AW'(i);
        for (int i = WAYS - 1; i >= 0; i--)
            if (!valid_vec[i]) victim = AW'(i);
    end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl
// Fully-associative write-back cache controller, true-LRU replacement,
// one word per line (tag = full address), fixed-latency single-port RAM.
// Ports:
//   clock, reset                  rising-edge clock, async active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_rw/req_addr/req_wdata     request: 1 = write
//   rsp_valid/rsp_data/rsp_miss   one-cycle response strobe, data/miss held
//   mem_addr/mem_wdata/mem_wren   RAM side; mem_rdata returned after MEM_LAT
//   busy_fill/busy_wb             RAM read / write-back in progress
// Optional: define ASSOC_CACHE_STATS_EN to add saturating 16-bit counters
//   stat_hits, stat_misses, stat_wbs.
//
// state | meaning
// IDLE  | ready for a request; hits and clean write misses complete here
// WB    | writing dirty victim to RAM for MEM_LAT cycles
// FILL  | reading missed word from RAM for MEM_LAT cycles
// RESP  | response cycle after a WB/FILL install; not ready
module assoc_cache_ctrl
    import assoc_cache_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int WAYS    = 4,
    parameter int MEM_LAT = 3
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_miss,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy_fill,
    output logic              busy_wb
`ifdef ASSOC_CACHE_STATS_EN
    ,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_misses,
    output logic [15:0]       stat_wbs
`endif
);

    localparam int AW = age_width(WAYS);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    typedef struct packed {
        line_flags_t       fl;
        logic [ADDR_W-1:0] tag;
        logic [DATA_W-1:0] data;
    } line_t;

    line_t             lines [WAYS];
    state_t            state, state_nxt;
    logic              run;
    logic [CW-1:0]     cnt;
    logic              cnt_tc, cnt_ld;
    logic              q_rw;
    logic [ADDR_W-1:0] q_addr;
    logic [DATA_W-1:0] q_wdata;
    logic [AW-1:0]     q_way;
    logic              accept, hit, victim_dirty;
    logic [AW-1:0]     hit_way, victim;
    logic [WAYS-1:0]   valid_vec;
    logic              touch_en;
    logic [AW-1:0]     touch_way;
    logic              inst_en, inst_dirty;
    logic [AW-1:0]     inst_way;
    logic [ADDR_W-1:0] inst_tag;
    logic [DATA_W-1:0] inst_data;
    logic              rsp_set, rsp_m;
    logic [DATA_W-1:0] rsp_d;
    logic              mem_ld, wb_ld;
    logic [ADDR_W-1:0] mem_addr_d;

    // run keeps ready low until the first edge after reset release.
    assign req_ready    = run && (state == ST_IDLE);
    assign accept       = req_valid && req_ready;
    assign cnt_tc       = (cnt == '0);
    assign busy_wb      = (state == ST_WB);
    assign busy_fill    = (state == ST_FILL);
    assign mem_wren     = busy_wb;
    assign victim_dirty = lines[victim].fl.valid && lines[victim].fl.dirty;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            valid_vec[i] = lines[i].fl.valid;
            if (lines[i].fl.valid && lines[i].tag == req_addr) begin
                hit     = 1'b1;
                hit_way = AW'(i);
            end
        end
    end

    lru_age_table #(.WAYS(WAYS), .AW(AW)) u_lru (
        .clock     (clock),
        .reset     (reset),
        .touch_en  (touch_en),
        .touch_way (touch_way),
        .valid_vec (valid_vec),
        .victim    (victim)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        touch_en   = 1'b0;
        touch_way  = victim;
        inst_en    = 1'b0;
        inst_way   = victim;
        inst_tag   = req_addr;
        inst_data  = req_wdata;
        inst_dirty = 1'b1;
        rsp_set    = 1'b0;
        rsp_m      = 1'b0;
        rsp_d      = req_wdata;
        mem_ld     = 1'b0;
        wb_ld      = 1'b0;
        mem_addr_d = req_addr;
        cnt_ld     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (hit) begin
                        touch_en  = 1'b1;
                        touch_way = hit_way;
                        rsp_set   = 1'b1;
                        if (req_rw) begin
                            inst_en  = 1'b1;
                            inst_way = hit_way;
                        end else begin
                            rsp_d = lines[hit_way].data;
                        end
                    end else if (victim_dirty) begin
                        state_nxt  = ST_WB;
                        mem_ld     = 1'b1;
                        wb_ld      = 1'b1;
                        mem_addr_d = lines[victim].tag;
                        cnt_ld     = 1'b1;
                    end else if (req_rw) begin
                        // write-allocate without fetch: install immediately
                        inst_en  = 1'b1;
                        touch_en = 1'b1;
                        rsp_set  = 1'b1;
                        rsp_m    = 1'b1;
                    end else begin
                        state_nxt = ST_FILL;
                        mem_ld    = 1'b1;
                        cnt_ld    = 1'b1;
                    end
                end
            end
            ST_WB: begin
                if (cnt_tc) begin
                    if (q_rw) begin
                        state_nxt = ST_RESP;
                        inst_en   = 1'b1;
                        inst_way  = q_way;
                        inst_tag  = q_addr;
                        inst_data = q_wdata;
                        touch_en  = 1'b1;
                        touch_way = q_way;
                        rsp_set   = 1'b1;
                        rsp_m     = 1'b1;
                        rsp_d     = q_wdata;
                    end else begin
                        state_nxt  = ST_FILL;
                        mem_ld     = 1'b1;
                        mem_addr_d = q_addr;
                        cnt_ld     = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (cnt_tc) begin
                    state_nxt  = ST_RESP;
                    inst_en    = 1'b1;
                    inst_way   = q_way;
                    inst_tag   = q_addr;
                    inst_data  = mem_rdata;
                    inst_dirty = 1'b0;
                    touch_en   = 1'b1;
                    touch_way  = q_way;
                    rsp_set    = 1'b1;
                    rsp_m      = 1'b1;
                    rsp_d      = mem_rdata;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run       <= 1'b0;
            cnt       <= '0;
            q_rw      <= 1'b0;
            q_addr    <= '0;
            q_wdata   <= '0;
            q_way     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_miss  <= 1'b0;
            for (int i = 0; i < WAYS; i++) lines[i] <= '0;
        end else begin
            run       <= 1'b1;
            rsp_valid <= rsp_set;
            if (rsp_set) begin
                rsp_data <= rsp_d;
                rsp_miss <= rsp_m;
            end
            if (accept) begin
                q_rw    <= req_rw;
                q_addr  <= req_addr;
                q_wdata <= req_wdata;
                q_way   <= victim;
            end
            if (cnt_ld)       cnt <= CNT_LOAD;
            else if (!cnt_tc) cnt <= cnt - 1'b1;
            if (mem_ld) mem_addr  <= mem_addr_d;
            if (wb_ld)  mem_wdata <= lines[victim].data;
            if (inst_en)
                lines[inst_way] <= '{fl: '{valid: 1'b1, dirty: inst_dirty},
                                     tag: inst_tag, data: inst_data};
        end
    end

`ifdef ASSOC_CACHE_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbs    <= '0;
        end else begin
            if (rsp_set && !rsp_m && stat_hits != 16'hFFFF)
                stat_hits <= stat_hits + 16'd1;
            if (rsp_set && rsp_m && stat_misses != 16'hFFFF)
                stat_misses <= stat_misses + 16'd1;
            if (busy_wb && cnt_tc && stat_wbs != 16'hFFFF)
                stat_wbs <= stat_wbs + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
`timescale 1ns/1ps
module tb_assoc_cache_ctrl;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int WAYS    = 4;
    localparam int MEM_LAT = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid, rsp_miss;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_wren, busy_fill, busy_wb;
`ifdef ASSOC_CACHE_STATS_EN
    logic [15:0]       stat_hits, stat_misses, stat_wbs;
`endif

    always #5 clock = ~clock;

    assoc_cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .MEM_LAT(MEM_LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_miss  (rsp_miss),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_rdata (mem_rdata),
        .busy_fill (busy_fill),
        .busy_wb   (busy_wb)
`ifdef ASSOC_CACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses),
        .stat_wbs    (stat_wbs)
`endif
    );

    // RAM: data is only correct once the address has been stable MEM_LAT cycles.
    logic [DATA_W-1:0] ram [2**ADDR_W];
    int                run_n = 0;
    logic [ADDR_W-1:0] prev_a = '0;

    always @(negedge clock) begin
        if (mem_addr == prev_a) run_n = run_n + 1;
        else                    run_n = 1;
        prev_a = mem_addr;
    end
    always @(posedge clock) if (mem_wren) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = (run_n >= MEM_LAT) ? ram[mem_addr] : ~ram[mem_addr];

    // Reference cache: arrays plus a recency list (front = most recent).
    logic              m_valid [WAYS];
    logic              m_dirty [WAYS];
    logic [ADDR_W-1:0] m_tag   [WAYS];
    logic [DATA_W-1:0] m_data  [WAYS];
    int                lru_q[$];
    int                m_hits, m_misses, m_wbs;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        lru_q.delete();
        for (int i = 0; i < WAYS; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            lru_q.push_back(i);
        end
        m_hits = 0; m_misses = 0; m_wbs = 0;
    endfunction

    function automatic void model_touch(input int w);
        for (int i = 0; i < lru_q.size(); i++)
            if (lru_q[i] == w) begin
                lru_q.delete(i);
                break;
            end
        lru_q.push_front(w);
    endfunction

    function automatic int model_victim();
        for (int i = 0; i < WAYS; i++) if (!m_valid[i]) return i;
        return lru_q[$];
    endfunction

    // Called at a negedge. With keep set (and a non-IDLE response) req_valid
    // stays high with a scrambled address until ready returns.
    task automatic run_req(input logic rw, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input bit keep);
        int hw, v, exp_lat, exp_wb, lat, wb_n, rdy_n, overlap, g;
        logic [ADDR_W-1:0] exp_wb_a, wb_a;
        logic [DATA_W-1:0] exp_d, exp_wb_d, wb_d;
        logic exp_miss;
        bit hold;
        hw = -1;
        for (int i = 0; i < WAYS; i++) if (m_valid[i] && m_tag[i] == addr) hw = i;
        exp_wb = 0; exp_wb_a = '0; exp_wb_d = '0;
        if (hw >= 0) begin
            exp_miss = 1'b0;
            exp_lat  = 1;
            exp_d    = rw ? wd : m_data[hw];
            if (rw) begin m_data[hw] = wd; m_dirty[hw] = 1'b1; end
            model_touch(hw);
            m_hits++;
        end else begin
            v = model_victim();
            exp_miss = 1'b1;
            if (m_valid[v] && m_dirty[v]) begin
                exp_wb = MEM_LAT; exp_wb_a = m_tag[v]; exp_wb_d = m_data[v];
                m_wbs++;
            end
            if (rw) begin
                exp_d   = wd;
                exp_lat = (exp_wb != 0) ? MEM_LAT + 1 : 1;
            end else begin
                exp_d   = ram[addr];
                exp_lat = ((exp_wb != 0) ? 2 * MEM_LAT : MEM_LAT) + 1;
            end
            m_valid[v] = 1'b1; m_dirty[v] = rw; m_tag[v] = addr; m_data[v] = exp_d;
            model_touch(v);
            m_misses++;
        end
        hold = keep && (exp_lat > 1);

        g = 0;
        while (!req_ready && g < 100) begin @(negedge clock); g++; end
        check("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
        @(negedge clock);
        if (!hold) req_valid = 1'b0;
        lat = 1; wb_n = 0; rdy_n = 0; overlap = 0; wb_a = '0; wb_d = '0;
        while (!rsp_valid && lat < 4 * MEM_LAT + 8) begin
            if (mem_wren) begin wb_n++; wb_a = mem_addr; wb_d = mem_wdata; end
            if (mem_wren && busy_fill) overlap++;
            if (req_ready) rdy_n++;
            if (hold) req_addr = ADDR_W'($urandom);
            @(negedge clock);
            lat++;
        end
        if (req_ready) rdy_n++;
        check("latency", lat, exp_lat);
        check("rsp_data", rsp_data, exp_d);
        check("rsp_miss", rsp_miss, exp_miss);
        check("wb_cycles", wb_n, exp_wb);
        if (exp_wb != 0) begin
            check("wb_addr", wb_a, exp_wb_a);
            check("wb_data", wb_d, exp_wb_d);
        end
        check("ready_while_busy", rdy_n, (exp_lat == 1) ? 1 : 0);
        check("wb_fill_overlap", overlap, 0);
        if (hold) req_addr = ADDR_W'($urandom);
        @(negedge clock);
        check("rsp_one_cycle", rsp_valid, 1'b0);
        check("rsp_data_hold", rsp_data, exp_d);
    endtask

    initial begin
        int v;
        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = DATA_W'($urandom);
        ram[5] = 8'hA5;
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_mem_wren", mem_wren, 1'b0);
        check("rst_busy", {busy_fill, busy_wb}, 2'b00);
        check("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        #1 check("ready_before_edge", req_ready, 1'b0);
        @(negedge clock);
        check("ready_after_edge", req_ready, 1'b1);

        // read miss, read hit, three write misses, hit, dirty-victim read
        run_req(1'b0, 5'd5,  8'h00, 1'b0);
        check("t1_data", rsp_data, 8'hA5);
        run_req(1'b0, 5'd5,  8'h00, 1'b0);
        run_req(1'b1, 5'd9,  8'h3C, 1'b0);
        run_req(1'b1, 5'd12, 8'h11, 1'b0);
        run_req(1'b1, 5'd20, 8'h77, 1'b0);
        run_req(1'b0, 5'd5,  8'h00, 1'b0);
        run_req(1'b0, 5'd30, 8'h00, 1'b0);

        // reset in the second write-back cycle
        v = model_victim();
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 5'd7;
        @(negedge clock);
        req_valid = 1'b0;
        check("abort_wb_started", mem_wren, m_valid[v] && m_dirty[v]);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_wren", mem_wren, 1'b0);
        check("abort_busy_wb", busy_wb, 1'b0);
        check("abort_ready", req_ready, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1 check("ready_after_abort", req_ready, 1'b1);
        @(negedge clock);
        run_req(1'b0, 5'd5, 8'h00, 1'b0);

        // requester holds a changing request through a fill
        run_req(1'b0, 5'd17, 8'h00, 1'b1);
        run_req(1'b0, 5'd5,  8'h00, 1'b0);

        for (int n = 0; n < 300; n++)
            run_req(1'($urandom), ADDR_W'($urandom_range(0, 2**ADDR_W - 1)),
                    DATA_W'($urandom), ($urandom_range(0, 3) == 0));

`ifdef ASSOC_CACHE_STATS_EN
        check("stat_hits", stat_hits, m_hits);
        check("stat_misses", stat_misses, m_misses);
        check("stat_wbs", stat_wbs, m_wbs);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
